// File: rtl/fir_adder_arbiter.sv
// Round-robin arbiter sharing one W-bit XOR/MUX ripple-carry adder between N requesters.
// Define FIR_ADDER_ARB_SAT_EN for signed saturation with an rsp_ovf flag.
module fir_adder_arbiter #(
    parameter int N       = 4,
    parameter int W       = 32,
    parameter int ADD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       a_flat,
    input  logic [N*W-1:0]       b_flat,
    output logic [N-1:0]         gnt,
    output logic                 busy,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [W-1:0]         rsp_sum,
    output logic                 rsp_cout,
`ifdef FIR_ADDER_ARB_SAT_EN
    output logic                 rsp_ovf,
`endif
    output logic [$clog2(N)-1:0] rsp_id
);

    localparam int IDW = $clog2(N);
    localparam int CW  = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic [IDW-1:0] id_q, id_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [W-1:0]   rsp_sum_q, rsp_sum_d;
    logic           rsp_cout_q, rsp_cout_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic           rsp_ovf_q, rsp_ovf_d;

    logic           win_found;
    logic [IDW-1:0] win_idx, cand;
    logic [W-1:0]   add_sum, sum_res;
    logic           add_cout, carry, prop, ovf;

    // Rotating priority: first set request at or above the pointer, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDW'((int'(rr_q) + k) % N);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Shared adder sees only the captured operands, never the live request bus.
    always_comb begin
        add_sum = '0;
        carry   = 1'b0;
        prop    = 1'b0;
        for (int i = 0; i < W; i++) begin
            prop       = op_a_q[i] ^ op_b_q[i];
            add_sum[i] = prop ^ carry;
            carry      = prop ? carry : op_a_q[i];
        end
        add_cout = carry;
    end

    always_comb begin
        ovf     = 1'b0;
        sum_res = add_sum;
`ifdef FIR_ADDER_ARB_SAT_EN
        ovf = (op_a_q[W-1] == op_b_q[W-1]) && (add_sum[W-1] != op_a_q[W-1]);
        if (ovf)
            sum_res = op_a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_id_d    = rsp_id_q;
        rsp_ovf_d   = rsp_ovf_q;
        gnt         = '0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    gnt     = N'(1) << win_idx;
                    op_a_d  = a_flat[int'(win_idx)*W +: W];
                    op_b_d  = b_flat[int'(win_idx)*W +: W];
                    id_d    = win_idx;
                    rr_d    = (win_idx == IDW'(N-1)) ? '0 : win_idx + 1'b1;
                    cnt_d   = CW'(ADD_LAT - 1);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rsp_sum_d   = sum_res;
                    rsp_cout_d  = add_cout;
                    rsp_id_d    = id_q;
                    rsp_ovf_d   = ovf;
                    rsp_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_ovf_d   = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            cnt_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= '0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_id_q    <= rsp_id_d;
            rsp_ovf_q   <= rsp_ovf_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = rsp_id_q;
`ifdef FIR_ADDER_ARB_SAT_EN
    assign rsp_ovf   = rsp_ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = rsp_ovf_q ^ ovf;
`endif

endmodule
